// File: rtl/ram_dma_pkg.sv
// Shared types and default sizes for the ram_dma block-transfer engine.
package ram_dma_pkg;

    localparam int unsigned DefaultWordSize = 16;
    localparam int unsigned DefaultAddrSize = 8;

    typedef enum logic {
        DMA_OP_COPY = 1'b0,
        DMA_OP_FILL = 1'b1
    } dma_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

endpackage

// File: rtl/ram_dma.sv
// Block COPY/FILL initiator driving the address/load/in port of a single-port RAM.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int unsigned WORD_W = DefaultWordSize,
    parameter int unsigned ADDR_W = DefaultAddrSize
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic [WORD_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [WORD_W-1:0] ram_value
);

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    dma_state_e        state_q, state_d;
    dma_op_e           op_q, op_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [WORD_W-1:0] in_q, in_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        in_d    = in_q;
        addr_d  = addr_q;
        load_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = dma_op_e'(op);
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = count;
                    if (count == '0) begin
                        state_d = ST_DONE;
                    end else if (dma_op_e'(op) == DMA_OP_COPY) begin
                        state_d = ST_RD;
                        addr_d  = src_addr;
                    end else begin
                        state_d = ST_WR;
                        addr_d  = dst_addr;
                        in_d    = fill_value;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WR;
                in_d    = ram_value;
                addr_d  = dst_q;
                load_d  = 1'b1;
            end
            ST_WR: begin
                // The write itself lands at this edge; pointers advance past it.
                src_d = src_q + AddrOne;
                dst_d = dst_q + AddrOne;
                rem_d = rem_q - AddrOne;
                if (rem_q == AddrOne) begin
                    state_d = ST_DONE;
                end else if (op_q == DMA_OP_COPY) begin
                    state_d = ST_RD;
                    addr_d  = src_q + AddrOne;
                end else begin
                    addr_d  = dst_q + AddrOne;
                    load_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RD) || (state_d == ST_WR);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= DMA_OP_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            in_q    <= '0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            in_q    <= in_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_in      = in_q;
    assign ram_address = addr_q;
    assign ram_load    = load_q;

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
- Sequencing initiator for the single-port `ram` block: the requester end of its in/address/load/value interface.
- Executes one block operation per start command:
  - COPY: N words from a source base to a destination base.
  - FILL: N words at a destination base with a constant.
- Sits beside the CPU datapath and owns the RAM port while busy. The surrounding glue muxes the RAM port between the CPU and this block using busy.

Parameters:
- WORD_W, default `DefaultWordSize, data word width.
- ADDR_W, default `DefaultAddrSize, RAM address width.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  command strobe, sampled only in IDLE.
- op  input  1  0 = COPY, 1 = FILL.
- src_addr  input  ADDR_W  COPY source base.
- dst_addr  input  ADDR_W  destination base.
- count  input  ADDR_W  word count N; 0 = no-op.
- fill_value  input  WORD_W  FILL data.
- busy  output  1  high in RD/WR states.
- done  output  1  one-cycle completion pulse.
- ram_in  output  WORD_W  to ram in.
- ram_address  output  ADDR_W  to ram address.
- ram_load  output  1  to ram load.
- ram_value  input  WORD_W  from ram value; combinational read of ram_address.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, reset_n). All outputs are registered.
- RAM contract: ram_value reflects ram_address combinationally. RAM writes ram_in at a rising edge where ram_load=1.
- Reset values: busy=0, done=0, ram_load=0, ram_address=0, ram_in=0. State=IDLE, internal counters 0.
- States: IDLE, RD, WR, DONE.
- Command latch: on start in IDLE, src_addr, dst_addr, count, op and fill_value are captured. Input changes after that have no effect.
- IDLE + start, count=0: next state DONE; no RAM access.
- IDLE + start, COPY: next state RD, ram_address=src, ram_load=0.
- IDLE + start, FILL: next state WR, ram_address=dst, ram_in=fill_value, ram_load=1.
- RD:
  - At the next edge, ram_in<=ram_value, ram_address<=current dst pointer, ram_load<=1.
  - Next state WR.
- WR (the RAM write occurs at the edge leaving WR):
  - Both pointers increment modulo 2^ADDR_W (wrap from all-ones to 0). Remaining count decrements.
  - If remaining reaches 0: next state DONE, ram_load<=0.
  - Else COPY: next state RD, ram_address<=src pointer, ram_load<=0.
  - Else FILL: stay in WR, ram_address<=dst pointer, ram_load=1.
- DONE: done=1, busy=0 for exactly one cycle. Next state IDLE.
- start is ignored in RD, WR and DONE (no queuing).
- Latency, start sampled at edge 0:
  - COPY of N words: writes at edges 2,4,...,2N; done high in the cycle after edge 2N.
  - FILL of N words: writes at edges 1..N; done high in the cycle after edge N.
  - count=0: done high in the cycle after edge 0.
- Overlap: COPY always ascends one word at a time, read before write.
  - dst>src with overlap propagates already-copied words; this is defined behaviour, not an error.
  - dst==src rewrites identical data.
- Reset mid-operation: reset_n low sampled at an edge forces IDLE and reset values.
  - If ram_load was 1 going into that edge, that single write completes at that edge; no write follows.
  - No done pulse is issued for an aborted operation.
- ram_load is never high outside WR.

Decomposition:
- Add `DmaOpCopy (1'b0) and `DmaOpFill (1'b1) to const.h, alongside the existing word/address size macros and `ClockPulseWidth.
- Add state encoding macros for IDLE/RD/WR/DONE there.
- No sub-module: pointers, counter and FSM fit in one module.
- Bench instantiates the existing `ram` as the responder.

Test Plan:
- Fill: reset, start FILL dst=4 count=3 fill_value=7 → RAM[4..6]=7, RAM[7] unchanged. Writes at edges 1-3; done pulse of 1 cycle; busy high for exactly 3 cycles.
- Copy: preload RAM[0]=3, RAM[1]=2; start COPY src=0 dst=8 count=2 → RAM[8]=3, RAM[9]=2. ram_load high on alternate cycles only; done in the cycle after edge 4.
- Wrap: start FILL dst=all-ones count=2 fill_value=5 → RAM[max]=5, RAM[0]=5; done asserted; no other address written.
- Zero count and busy-time start: start count=0 → done in the next cycle, ram_load never asserted. A second start pulsed mid-COPY is ignored; the final RAM contents match the first command only.
- Reset abort: start FILL dst=0 count=4 fill_value=9, drop reset_n before edge 3 → RAM[0..2]=9, RAM[3] unchanged. No done pulse; all outputs return to reset values.
- Overlap: RAM[0]=1, RAM[1]=2, COPY src=0 dst=1 count=2 → RAM[1]=1, RAM[2]=1.
